// File: rtl/irq_arbiter.sv
`timescale 1ns/1ps
// Purpose: synchronise NSRC async interrupt lines, latch rising edges, round-robin grant one at a time to the core.
// Latency: source edge to ir_out = 4 cycles (2 sync, 1 pending, 1 grant); grant to ir_out = 1 cycle.
// Backpressure: one grant in flight; new grants wait for eret + GAP_LEN and ir_en=1, pending bits are never dropped.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   irq_src[NSRC]       raw asynchronous interrupt lines
//   mask_we/mask_wdata  mask register write (bit=1 enables source)
//   ir_en               global enable from the core (blocks new grants only)
//   eret                one-cycle pulse, core finished servicing
//   ir_out              registered interrupt request pulse (PULSE_LEN cycles)
//   ir_id               index of the granted / in-service source
//   busy                high from grant until eret accepted
//   pending, mask       latched pending bits (unmasked) and mask register
module irq_arbiter #(
    parameter int NSRC      = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         irq_src,
    input  logic                    mask_we,
    input  logic [NSRC-1:0]         mask_wdata,
    input  logic                    ir_en,
    input  logic                    eret,
    output logic                    ir_out,
    output logic [$clog2(NSRC)-1:0] ir_id,
    output logic                    busy,
    output logic [NSRC-1:0]         pending,
    output logic [NSRC-1:0]         mask
);

    localparam int IDW  = $clog2(NSRC);
    localparam int CMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] prev;
    logic [2:0]      arm;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] grant_oh;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic            grant_vld;
    logic            grant;
    int              idx;

    // Synchroniser and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            arm   <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            prev  <= sync2;
            arm   <= {arm[1:0], 1'b1};
        end
    end

    // Edge detection is held off until both sync2 and prev carry real samples
    // taken after reset, so a line that was already high at reset release
    // never looks like a fresh low-to-high transition.
    always_comb rise = arm[2] ? (sync2 & ~prev) : '0;

    assign eligible = pending & mask;

    // Round-robin search from rr_ptr. Walking from the far end down lets the
    // lowest offset (first eligible after rr_ptr) overwrite any later hit.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NSRC;
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    assign grant = (state == IDLE) && ir_en && grant_vld;

    always_comb begin
        grant_oh = '0;
        if (grant) grant_oh[grant_idx] = 1'b1;
    end

    // Pending clear and new edge on the same cycle: the edge wins so the
    // second request survives the grant of the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '1;
            rr_ptr  <= '0;
        end else begin
            pending <= (pending & ~grant_oh) | rise;
            if (mask_we) mask <= mask_wdata;
            if (grant) rr_ptr <= (grant_idx == IDW'(NSRC - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // Grant FSM; ir_out/busy/ir_id are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ir_out <= 1'b0;
            busy   <= 1'b0;
            ir_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state  <= REQ;
                        cnt    <= CW'(PULSE_LEN - 1);
                        ir_out <= 1'b1;
                        busy   <= 1'b1;
                        ir_id  <= grant_idx;
                    end
                end
                REQ: begin
                    if (cnt == '0) begin
                        state  <= SERVICE;
                        ir_out <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state <= GAP;
                        cnt   <= CW'(GAP_LEN - 1);
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    ir_out <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
`timescale 1ns/1ps
module tb_irq_arbiter;

    localparam int NSRC      = 4;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 2;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;
    localparam int P_GAP  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSRC-1:0] irq_src;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            ir_en;
    logic            eret;
    logic            ir_out;
    logic [1:0]      ir_id;
    logic            busy;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;

    int n_cmp = 0;
    int n_bad = 0;

    irq_arbiter #(.NSRC(NSRC), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .ir_en(ir_en), .eret(eret), .ir_out(ir_out),
        .ir_id(ir_id), .busy(busy), .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NSRC-1:0] m_pend, m_mask;
    logic [NSRC-1:0] smp [3];
    int m_rr, m_phase, m_left, m_id, m_n;

    task automatic model_reset();
        m_pend = '0; m_mask = '1; m_rr = 0; m_phase = P_IDLE;
        m_left = 0; m_id = 0; m_n = 0;
        for (int k = 0; k < 3; k++) smp[k] = '0;
    endtask

    // One clock edge: inputs as currently driven are what the DUT samples.
    task automatic model_step();
        logic [NSRC-1:0] ne, elig;
        int g;
        m_n = m_n + 1;
        // edge seen at sample m_n-2 vs m_n-3; needs both samples post-reset
        ne   = (m_n >= 4) ? (smp[1] & ~smp[2]) : '0;
        elig = m_pend & m_mask;
        case (m_phase)
            P_IDLE: begin
                if (ir_en && elig != 0) begin
                    g = -1;
                    for (int k = 0; k < NSRC; k++)
                        if (g < 0 && elig[(m_rr + k) % NSRC]) g = (m_rr + k) % NSRC;
                    m_pend[g] = 1'b0;
                    m_id      = g;
                    m_rr      = (g + 1) % NSRC;
                    m_phase   = P_REQ;
                    m_left    = PULSE_LEN;
                end
            end
            P_REQ: begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = P_SVC;
            end
            P_SVC: begin
                if (eret) begin m_phase = P_GAP; m_left = GAP_LEN; end
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = P_IDLE;
            end
        endcase
        m_pend = m_pend | ne;
        if (mask_we) m_mask = mask_wdata;
        smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = irq_src;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, input int limit, output int took);
        took = 0;
        while (took < limit && ir_out !== 1'b1) begin
            tick();
            took++;
        end
        chk(name, ir_out, 1);
    endtask

    // Called right after ir_out is first seen high: count pulse, then eret.
    task automatic serve(input string name);
        int k;
        k = 0;
        while (ir_out === 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk(name, k, PULSE_LEN);
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    typedef struct {
        logic [NSRC-1:0] irq;
        logic            en;
        logic            er;
        logic            exp_out;
        logic            exp_busy;
        logic [1:0]      exp_id;
        logic [NSRC-1:0] exp_pend;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int took;
        logic saw;
        logic [NSRC-1:0] flip;

        // single request on source 2, eret ignored in REQ (row 4)
        tbl[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[2] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100};
        tbl[3] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[4] = '{4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[5] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[6] = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000};
        tbl[7] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000};
        tbl[8] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000};

        irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ir_en = 1'b1; eret = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir_out", ir_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ir_id", ir_id, 0);
        chk("rst_pending", pending, 0);
        chk("rst_mask", mask, 4'hf);
        rst_n = 1'b1;
        repeat (4) tick();

        for (int r = 0; r < 9; r++) begin
            irq_src = tbl[r].irq;
            ir_en   = tbl[r].en;
            eret    = tbl[r].er;
            tick();
            chk($sformatf("tbl%0d_ir_out", r), ir_out, tbl[r].exp_out);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].exp_busy);
            chk($sformatf("tbl%0d_ir_id", r), ir_id, tbl[r].exp_id);
            chk($sformatf("tbl%0d_pending", r), pending, tbl[r].exp_pend);
        end
        eret = 1'b0;
        irq_src = '0;
        do_reset();

        // round robin: sources 0 and 3 together, rr_ptr=0
        irq_src = 4'b1001;
        wait_grant("rr_first_grant", 20, took);
        chk("rr_edge_latency", took, 4);
        chk("rr_first_id", ir_id, 0);
        serve("rr_first_pulse");
        wait_grant("rr_second_grant", 20, took);
        chk("rr_second_id", ir_id, 3);
        chk("rr_pending_end", pending, 0);
        serve("rr_second_pulse");
        irq_src = '0;
        repeat (4) tick();

        // masking gates arbitration but not pending capture
        mask_we = 1'b1; mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        chk("mask_load", mask, 4'b1110);
        irq_src = 4'b0001;
        saw = 1'b0;
        repeat (6) begin tick(); saw |= ir_out; end
        chk("mask_no_grant", saw, 0);
        chk("mask_pending", pending, 4'b0001);
        mask_we = 1'b1; mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        wait_grant("mask_grant", 10, took);
        chk("mask_grant_delay", took, 1);
        chk("mask_grant_id", ir_id, 0);
        serve("mask_pulse");
        irq_src = '0;
        repeat (4) tick();

        // ir_en low blocks, eret in IDLE ignored
        ir_en = 1'b0;
        irq_src = 4'b0010;
        saw = 1'b0;
        repeat (6) begin tick(); saw |= ir_out; end
        chk("en_no_grant", saw, 0);
        chk("en_pending", pending, 4'b0010);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        chk("idle_eret_busy", busy, 0);
        chk("idle_eret_ir_out", ir_out, 0);
        chk("idle_eret_pending", pending, 4'b0010);
        ir_en = 1'b1;
        tick();
        chk("en_grant", ir_out, 1);
        chk("en_grant_id", ir_id, 1);
        serve("en_pulse");
        irq_src = '0;
        repeat (4) tick();

        // new edge on source 1 lands on the cycle source 1 is granted
        ir_en = 1'b0;
        irq_src = 4'b0010;
        repeat (3) tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0010;
        tick();
        tick();
        ir_en = 1'b1;
        tick();
        chk("sim_grant", ir_out, 1);
        chk("sim_grant_id", ir_id, 1);
        chk("sim_pending_kept", pending, 4'b0010);
        serve("sim_pulse1");
        wait_grant("sim_regrant", 10, took);
        chk("sim_eret_to_grant", took, GAP_LEN + 1);
        chk("sim_regrant_id", ir_id, 1);
        chk("sim_pending_end", pending, 0);
        serve("sim_pulse2");
        irq_src = '0;
        repeat (4) tick();

        // async reset in SERVICE, then sources held high across release
        mask_we = 1'b1; mask_wdata = 4'b1101;
        tick();
        mask_we = 1'b0;
        irq_src = 4'b1100;
        wait_grant("ar_grant", 20, took);
        chk("ar_grant_id", ir_id, 2);
        repeat (PULSE_LEN) tick();
        chk("ar_service_busy", busy, 1);
        chk("ar_service_pending", pending, 4'b1000);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_ir_out", ir_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_pending", pending, 0);
        chk("ar_mask", mask, 4'hf);
        chk("ar_ir_id", ir_id, 0);
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin tick(); saw |= ir_out; end
        chk("held_high_no_grant", saw, 0);
        chk("held_high_pending", pending, 0);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NSRC; b++) flip[b] = ($urandom_range(0, 7) == 0);
            irq_src    = irq_src ^ flip;
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = NSRC'($urandom) | NSRC'($urandom);
            ir_en      = ($urandom_range(0, 7) != 0);
            eret       = ($urandom_range(0, 3) == 0);
            tick();
            chk("rnd_ir_out", ir_out, (m_phase == P_REQ) ? 1 : 0);
            chk("rnd_busy", busy, (m_phase == P_REQ || m_phase == P_SVC) ? 1 : 0);
            chk("rnd_ir_id", ir_id, 32'(m_id));
            chk("rnd_pending", pending, m_pend);
            chk("rnd_mask", mask, m_mask);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter NSRC, default 4, SHALL set the number of external interrupt sources (2..8).
REQ-002 Parameter PULSE_LEN, default 2, SHALL set the number of cycles ir_out stays high per grant (>=1).
REQ-003 Parameter GAP_LEN, default 2, SHALL set the minimum number of ir_out-low cycles after eret before the next grant (>=2).
REQ-004 clk  input  1  main clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 irq_src  input  NSRC  raw external interrupt lines, asynchronous to clk.
REQ-007 mask_we  input  1  write strobe for the mask register.
REQ-008 mask_wdata  input  NSRC  new mask value; bit=1 enables that source.
REQ-009 ir_en  input  1  global interrupt enable from the core.
REQ-010 eret  input  1  one-cycle pulse: the core executed ERET.
REQ-011 ir_out  output  1  interrupt request to the coprocessor ir_in input.
REQ-012 ir_id  output  $clog2(NSRC)  index of the source currently granted or in service.
REQ-013 busy  output  1  high from grant until eret is accepted.
REQ-014 pending  output  NSRC  latched pending bits, unmasked view.
REQ-015 mask  output  NSRC  current mask register.

Function
REQ-016 Each irq_src bit SHALL pass a 2-flop synchronizer, then a rising-edge detector (sync=1, previous sync=0).
REQ-017 A detected edge SHALL set the matching pending bit; the bit SHALL remain set until that source is granted.
REQ-018 An edge on a source in the same cycle it is granted SHALL leave its pending bit set, so a second request is not lost.
REQ-019 mask SHALL load mask_wdata on the cycle after mask_we; masking SHALL only gate arbitration, never clear or block pending bits.
REQ-020 Eligible set = pending & mask; a grant SHALL occur only in IDLE with ir_en=1 and a non-empty eligible set.
REQ-021 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NSRC; the first eligible index wins.
REQ-022 On a grant, rr_ptr SHALL become (granted index + 1) mod NSRC, ir_id SHALL load the granted index, and that pending bit SHALL clear (subject to REQ-018).
REQ-023 FSM states: IDLE, REQ, SERVICE, GAP.
REQ-024 IDLE -> REQ on grant; in REQ, ir_out=1 for exactly PULSE_LEN cycles, then -> SERVICE.
REQ-025 In SERVICE, ir_out=0; eret=1 -> GAP.
REQ-026 In GAP, ir_out=0 for exactly GAP_LEN cycles, then -> IDLE.
REQ-027 eret SHALL be ignored in IDLE, REQ and GAP.
REQ-028 busy SHALL be 1 in REQ and SERVICE and 0 in IDLE and GAP.
REQ-029 ir_id SHALL hold its value through REQ, SERVICE and GAP.
REQ-030 ir_en deasserting SHALL not abort a grant in progress; it only blocks new grants.
REQ-031 ir_out SHALL be driven directly from a flop, glitch-free.
REQ-032 Grant-to-ir_out latency SHALL be 1 cycle: ir_out rises on the clock edge that enters REQ.
REQ-033 Edge-to-ir_out latency from an idle, enabled, unmasked state SHALL be 4 cycles: 2 synchronizer cycles, 1 pending cycle, 1 grant cycle.

Reset
REQ-034 While rst_n=0, the block SHALL immediately (asynchronously) reset to: state=IDLE, ir_out=0, busy=0, ir_id=0, pending=0, mask=all ones, rr_ptr=0, synchronizer and edge flops=0.
REQ-035 Reset asserted mid-REQ or mid-SERVICE SHALL drop ir_out and busy at once and discard all pending bits.
REQ-036 After rst_n rises, a source already high SHALL not create an edge; a new edge requires a low-to-high transition.

Verification
REQ-037 Single request: mask=4'b1111, ir_en=1, irq_src[2] rises -> ir_out high 4 cycles later for 2 cycles, ir_id=2, busy=1; eret -> busy=0, IDLE reached after 2 GAP cycles.
REQ-038 Round-robin: irq_src[0] and irq_src[3] rise together, rr_ptr=0 -> grant 0 first; after eret and GAP -> grant 3; pending=0 at the end.
REQ-039 Masking: mask=4'b1110, irq_src[0] rises -> no ir_out, pending[0]=1; write mask=4'b1111 -> grant 0 within 2 cycles.
REQ-040 Simultaneous: edge on source 1 in its grant cycle -> pending[1] stays 1; second grant of 1 occurs after the first eret plus GAP.
REQ-041 ir_en and eret: ir_en=0 with pending[1]=1 -> no grant; eret pulsed in IDLE -> no state change; ir_en=1 -> grant 1.
REQ-042 Reset mid-operation: rst_n=0 during SERVICE -> ir_out=0, busy=0, pending=0, mask=4'b1111 immediately, without waiting for a clock edge.
